// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: FSM states, lane geometry and the word type.
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 8;
    localparam int unsigned LANE_SEL_W     = 2;
    localparam int unsigned CNT_W          = 4;

    typedef logic [LANE_W-1:0]     mem_word_t [0:BYTES_PER_WORD-1];
    typedef logic [LANE_SEL_W-1:0] lane_sel_t;

    // Which word lane lands in a given byte bank for an access starting at byte offset 'offset'.
    function automatic lane_sel_t lane_of_bank(input lane_sel_t bank, input lane_sel_t offset);
        return lane_sel_t'(bank - offset);
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Four independent byte-wide RAM banks, each with its own row address, write enable and registered read.
module byte_lane_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned ROW_W = 14
)(
    input  logic                      clk,
    input  logic [BYTES_PER_WORD-1:0] we,
    input  logic [ROW_W-1:0]          row [0:BYTES_PER_WORD-1],
    input  mem_word_t                 wdata,
    output mem_word_t                 rdata
);
    localparam int unsigned DEPTH = 1 << ROW_W;

    logic [LANE_W-1:0] mem [0:BYTES_PER_WORD-1][0:DEPTH-1];

    // Storage is deliberately not reset; read returns the pre-write contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (we[k]) begin
                mem[k][row[k]] <= wdata[k];
            end
            rdata[k] <= mem[k][row[k]];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS load/store port with req/ready handshake and fixed access latency.
// Optional per-lane store enables are built in when DATA_MEM_BYTE_EN is defined.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned LATENCY   = 2
)(
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      mem_req,
    input  logic [31:0]               mem_addr,
    input  logic                      mem_write_en,
    input  mem_word_t                 mem_data_in,
`ifdef DATA_MEM_BYTE_EN
    input  logic [BYTES_PER_WORD-1:0] mem_byte_en,
`endif
    output mem_word_t                 mem_data_out,
    output logic                      mem_ready,
    output logic                      mem_err,
    input  logic                      halted
);
    localparam int unsigned      ROW_W    = ADDR_BITS - 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_t                state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [ADDR_BITS-1:0]      addr_q;
    logic                      we_q;
    mem_word_t                 wdata_q;
    logic                      accept_c, access_c, misalign_c;
    logic [BYTES_PER_WORD-1:0] lane_en_c;
    logic [ADDR_BITS-1:0]      base_c;
    logic [ROW_W-1:0]          row_c [0:BYTES_PER_WORD-1];
    logic [BYTES_PER_WORD-1:0] ram_we_c;
    mem_word_t                 ram_wdata_c;
    mem_word_t                 ram_q;
    logic                      addr_hi_unused;

    assign addr_hi_unused = ^mem_addr[31:ADDR_BITS];

    // Next-state logic; mem_req is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        access_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_req && !halted) begin
                    accept_c  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access_c  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture; later changes on the bus are ignored
    always_ff @(posedge clk) begin
        if (accept_c) begin
            addr_q  <= mem_addr[ADDR_BITS-1:0];
            we_q    <= mem_write_en;
            wdata_q <= mem_data_in;
        end
    end

`ifdef DATA_MEM_BYTE_EN
    logic [BYTES_PER_WORD-1:0] be_q;

    always_ff @(posedge clk) begin
        if (accept_c) begin
            be_q <= mem_byte_en;
        end
    end

    assign lane_en_c = be_q;

    // Stores are checked against the enabled span only; loads are always whole words
    always_comb begin
        misalign_c = (addr_q[1:0] != '0);
        if (we_q) begin
            if ($countones(be_q) <= 1) begin
                misalign_c = 1'b0;
            end else if (be_q[3:2] == '0) begin
                misalign_c = addr_q[0];
            end
        end
    end
`else
    assign lane_en_c  = '1;
    assign misalign_c = (addr_q[1:0] != '0);
`endif

    // While IDLE the RAM pre-reads at the incoming address so load data is ready by the access edge
    assign base_c = (state == IDLE) ? mem_addr[ADDR_BITS-1:0] : addr_q;

    always_comb begin
        row_c       = '{default: '0};
        ram_we_c    = '0;
        ram_wdata_c = '{default: '0};
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            row_c[k] = ROW_W'((base_c + ADDR_BITS'(lane_of_bank(LANE_SEL_W'(k), base_c[1:0]))) >> 2);
            ram_wdata_c[k] = wdata_q[lane_of_bank(LANE_SEL_W'(k), base_c[1:0])];
            ram_we_c[k]    = access_c & we_q & ~misalign_c
                           & lane_en_c[lane_of_bank(LANE_SEL_W'(k), base_c[1:0])];
        end
    end

    byte_lane_ram #(
        .ROW_W (ROW_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .row   (row_c),
        .wdata (ram_wdata_c),
        .rdata (ram_q)
    );

    // Latency counter and registered completion outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt          <= '0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
            mem_data_out <= '{default: '0};
        end else begin
            mem_ready <= access_c;
            mem_err   <= access_c & misalign_c;
            if (accept_c) begin
                cnt <= CNT_INIT;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access_c && !we_q) begin
                for (int i = 0; i < BYTES_PER_WORD; i++) begin
                    mem_data_out[i] <= misalign_c ? '0
                                     : ram_q[LANE_SEL_W'(LANE_SEL_W'(i) + addr_q[1:0])];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
    import mips_mem_pkg::*;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_write_en = 1'b0;
    mem_word_t   mem_data_in;
    mem_word_t   mem_data_out;
    logic        mem_ready;
    logic        mem_err;
    logic        halted = 1'b0;
`ifdef DATA_MEM_BYTE_EN
    logic [3:0]  mem_byte_en = 4'hF;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] last_out = '0;
    bit          last_known = 1'b1;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_BITS(16), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
`ifdef DATA_MEM_BYTE_EN
        .mem_byte_en  (mem_byte_en),
`endif
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_data_in[i] = w[31-8*i -: 8];
    endtask

    function automatic logic [31:0] out_word();
        return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
    endfunction

    // Byte-addressed model: lane i lives at (addr + i) mod 64K, lane 0 is the MSB of the word
    task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         output bit err, output logic [31:0] rd, output bit known);
        int unsigned a;
        a     = addr & 32'h0000_FFFF;
        err   = (addr % 4) != 0;
        rd    = '0;
        known = 1'b1;
`ifdef DATA_MEM_BYTE_EN
        if (we) begin
            if ($countones(mem_byte_en) <= 1) err = 1'b0;
            else if (mem_byte_en[3:2] == 2'b00) err = addr[0];
        end
`endif
        for (int i = 0; i < 4; i++) begin
            int unsigned b;
            bit en;
            b  = (a + i) % 65536;
            en = 1'b1;
`ifdef DATA_MEM_BYTE_EN
            en = mem_byte_en[i];
`endif
            if (we) begin
                if (!err && en) ref_mem[b] = wd[31-8*i -: 8];
            end else if (!err) begin
                if (ref_mem.exists(b)) rd[31-8*i -: 8] = ref_mem[b];
                else known = 1'b0;
            end
        end
    endtask

    // One handshake: request, scramble the bus after acceptance, wait (bounded) for the ready pulse
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input bit raise_halt, input string tag);
        bit          exp_err, known;
        logic [31:0] exp_rd;
        int          seen;
        model(we, addr, wd, exp_err, exp_rd, known);
        @(negedge clk);
        mem_req      = 1'b1;
        mem_write_en = we;
        mem_addr     = addr;
        set_word(wd);
        @(posedge clk);
        #1;
        mem_addr     = $urandom;
        mem_write_en = ~we;
        set_word($urandom);
        seen = 0;
        for (int k = 1; k <= int'(LAT) + 6 && seen == 0; k++) begin
            @(negedge clk);
            if (raise_halt && k == 1) halted = 1'b1;
            if (mem_ready === 1'b1) seen = k;
        end
        chk({tag, "_latency"}, 32'(seen), 32'(LAT + 1));
        if (seen != 0) begin
            chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, exp_err});
            if (!we) begin
                if (known) chk({tag, "_rdata"}, out_word(), exp_rd);
                last_out   = exp_rd;
                last_known = known;
            end else if (!exp_err && last_known) begin
                chk({tag, "_hold"}, out_word(), last_out);
            end
        end
        mem_req = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, mem_ready}, 32'd0);
    endtask

    initial begin
        int          nready;
        logic [31:0] a;
        set_word('0);
        #12;
        chk("reset_ready", {31'd0, mem_ready}, 32'd0);
        chk("reset_err", {31'd0, mem_err}, 32'd0);
        chk("reset_data", out_word(), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        do_access(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, "st10");
        do_access(0, 32'h0000_0010, 32'h0, 0, "ld10");

        do_access(1, 32'h0001_FFFC, 32'h1122_3344, 0, "st_wrap");
        do_access(0, 32'h0000_FFFC, 32'h0, 0, "ld_wrap");

        do_access(0, 32'h0000_0013, 32'h0, 0, "ld_mis");
        do_access(0, 32'h0000_0010, 32'h0, 0, "ld_after_mis");

        // Reset in the middle of a store must discard it
        do_access(1, 32'h0000_0020, 32'h1234_5678, 0, "st20");
        do_access(0, 32'h0000_0010, 32'h0, 0, "ld_pre_rst");
        @(negedge clk);
        mem_req = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h20; set_word(32'hAABB_CCDD);
        @(negedge clk);
        rst_b = 1'b0; mem_req = 1'b0;
        #1;
        chk("rst_busy_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_busy_data", out_word(), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_err", {31'd0, mem_err}, 32'd0);
        chk("rst_hold_data", out_word(), 32'd0);
        rst_b = 1'b1;
        last_out = '0; last_known = 1'b1;
        nready = 0;
        repeat (6) begin @(negedge clk); if (mem_ready) nready++; end
        chk("rst_no_ready", 32'(nready), 32'd0);
        do_access(0, 32'h0000_0020, 32'h0, 0, "ld20_after_rst");

        // Halt raised during a load: it completes, then new requests are refused
        do_access(0, 32'h0000_0010, 32'h0, 1, "ld_halt");
        mem_req = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h10;
        nready = 0;
        repeat (10) begin @(negedge clk); if (mem_ready) nready++; end
        chk("halt_block", 32'(nready), 32'd0);
        mem_req = 1'b0; halted = 1'b0;

`ifdef DATA_MEM_BYTE_EN
        do_access(1, 32'h0000_0030, 32'hFFFF_FFFF, 0, "be_fill");
        mem_byte_en = 4'b0101;
        do_access(1, 32'h0000_0030, 32'h0102_0304, 0, "be_st");
        mem_byte_en = 4'hF;
        do_access(0, 32'h0000_0030, 32'h0, 0, "be_ld");
        mem_byte_en = 4'b0001;
        do_access(1, 32'h0000_0033, 32'h5500_0000, 0, "be_sb");
        mem_byte_en = 4'hF;
        do_access(0, 32'h0000_0030, 32'h0, 0, "be_ld2");
`endif

        // Prefill two small windows so random loads have known contents
        for (int i = 0; i < 16; i++) begin
            do_access(1, 32'(4 * i), $urandom, 0, "fill_lo");
            do_access(1, 32'hFFC0 + 32'(4 * i), $urandom, 0, "fill_hi");
        end
        for (int n = 0; n < 50; n++) begin
            a = ($urandom % 2 == 0) ? 32'($urandom_range(0, 63)) : 32'hFFC0 + 32'($urandom_range(0, 63));
            if ($urandom % 4 != 0) a = a & ~32'h3;
            a = a | ($urandom << 16);
            do_access($urandom % 2 == 1, a, $urandom, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end

endmodule
